pwm_cmd_ctrl: RTL

- Command sequencer between the SPI slave receive path and the 400 Hz PWM channel bank.
- Parses the received byte stream into write-compare and enable-mask commands and holds them in shadow registers.
- Commits shadows to the active PWM configuration only at the PWM period boundary, so a pulse is never glitched mid-period.
- Reports status back for the SPI MISO response byte.

---
 rtl/pwm_cmd_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pwm_cmd_ctrl.sv
// SPI command sequencer for the PWM bank: parses byte frames into
// shadow registers and commits them to the active set on period wrap.
module pwm_cmd_ctrl #(
  parameter int NCH     = 4,
  parameter int CW      = 16,
  parameter int MAX_CMP = 50000,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              cs_n,
  input  logic              period_start,
  output logic [NCH*CW-1:0] cmp_out,
  output logic [NCH-1:0]    ch_en,
  output logic              commit,
  output logic [7:0]        status
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE, GET_HI, GET_LO, GET_MASK
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ch_q, ch_d;
  logic [7:0]             hi_q, hi_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [3:0]             err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [NCH-1:0][CW-1:0] shd_q, shd_d;
  logic [NCH-1:0][CW-1:0] cmp_q, cmp_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         msk_q, msk_d;
  logic                   pmsk_q, pmsk_d;
  logic [NCH-1:0]         en_q, en_d;
  logic                   commit_q, commit_d;

  logic          rx;
  logic          err_inc;
  logic          clr;
  logic [15:0]   raw;
  logic          ovr;
  logic [CW-1:0] clamped;
  logic          ch_ok;
  logic          tmo_hit;

  assign rx      = rx_valid & ~cs_n;
  assign raw     = {hi_q, rx_byte};
  assign ovr     = 32'(raw) > 32'(MAX_CMP);
  assign clamped = ovr ? CW'(MAX_CMP) : CW'(raw);
  assign ch_ok   = 32'(ch_q) < 32'(NCH);
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    shd_d    = shd_q;
    cmp_d    = cmp_q;
    pend_d   = pend_q;
    msk_d    = msk_q;
    pmsk_d   = pmsk_q;
    en_d     = en_q;
    err_inc  = 1'b0;
    clr      = 1'b0;
    commit_d = period_start & ((|pend_q) | pmsk_q);
    tmo_d    = (state_q == IDLE || rx) ? '0 : tmo_q + 1'b1;

    // Commit reads the old shadows; writes below re-arm pending.
    if (period_start) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend_q[i]) cmp_d[i] = shd_q[i];
      end
      pend_d = '0;
      if (pmsk_q) en_d = msk_q;
      pmsk_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (rx) begin
        unique case (rx_byte[7:6])
          2'b00: clr = rx_byte[0];
          2'b01: begin
            state_d = GET_HI;
            ch_d    = rx_byte[1:0];
          end
          2'b10: state_d = GET_MASK;
          2'b11: err_inc = 1'b1;
        endcase
      end
    end else if (cs_n) begin
      state_d = IDLE;
      err_inc = 1'b1;
      tmo_d   = '0;
    end else if (rx) begin
      state_d = IDLE;
      unique case (state_q)
        GET_HI: begin
          state_d = GET_LO;
          hi_d    = rx_byte;
        end
        GET_LO: begin
          if (ch_ok) begin
            shd_d[ch_q]  = clamped;
            pend_d[ch_q] = 1'b1;
            if (ovr) ovf_d = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
        default: begin
          msk_d  = rx_byte[NCH-1:0];
          pmsk_d = 1'b1;
        end
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      err_inc = 1'b1;
      tmo_d   = '0;
    end

    err_d = err_q;
    if (clr) begin
      err_d = '0;
      ovf_d = 1'b0;
    end else if (err_inc && err_q != 4'hF) begin
      err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      hi_q     <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
      shd_q    <= '0;
      cmp_q    <= '0;
      pend_q   <= '0;
      msk_q    <= '0;
      pmsk_q   <= 1'b0;
      en_q     <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      hi_q     <= hi_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      shd_q    <= shd_d;
      cmp_q    <= cmp_d;
      pend_q   <= pend_d;
      msk_q    <= msk_d;
      pmsk_q   <= pmsk_d;
      en_q     <= en_d;
      commit_q <= commit_d;
    end
  end

  assign cmp_out = cmp_q;
  assign ch_en   = en_q;
  assign commit  = commit_q;
  assign status  = {state_q != IDLE, (|pend_q) | pmsk_q,
                    ovf_q, 1'b0, err_q};

endmodule
